// File: rtl/prog_mem_pkg.sv
// Shared types and default sizes for the program-memory arbiter.
package prog_mem_pkg;

  localparam int ADDR_W_DEF     = 11;
  localparam int DATA_W_DEF     = 8;
  localparam int FETCH_AW_DEF   = 8;
  localparam int MAX_STREAK_DEF = 4;

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    LOCK_PEND = 2'd1,
    LOCKED    = 2'd2
  } lock_state_t;

endpackage

// File: rtl/prog_mem_arbiter_if.sv
// Fetch, loader and BRAM port-A signals of the program-memory arbiter.
import prog_mem_pkg::*;

interface prog_mem_arbiter_if #(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int FETCH_AW = FETCH_AW_DEF
);
  logic                f_req;
  logic [FETCH_AW-1:0] f_addr;
  logic                f_ack;
  logic                f_rvalid;
  logic [DATA_W-1:0]   f_rdata;

  logic                l_req;
  logic                l_we;
  logic [ADDR_W-1:0]   l_addr;
  logic [DATA_W-1:0]   l_wdata;
  logic                l_lock;
  logic                l_ack;
  logic                l_rvalid;
  logic [DATA_W-1:0]   l_rdata;

  logic [ADDR_W-1:0]   m_addr;
  logic                m_we;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W-1:0]   m_rdata;

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, m_rdata,
    output f_ack, f_rvalid, f_rdata, l_ack, l_rvalid, l_rdata, m_addr, m_we, m_wdata
  );

  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, m_rdata,
    input  f_ack, f_rvalid, f_rdata, l_ack, l_rvalid, l_rdata, m_addr, m_we, m_wdata
  );
endinterface

// File: rtl/prog_mem_lock_fsm.sv
// Loader lock state machine plus tracking of reads in flight.
//   state     | meaning
//   UNLOCKED  | normal arbitration between fetch and loader
//   LOCK_PEND | lock requested, waiting one cycle for the fetch read to land
//   LOCKED    | loader owns the memory, fetch stalled
import prog_mem_pkg::*;

module prog_mem_lock_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        l_lock,
  input  logic        f_rd_issue,
  input  logic        l_rd_issue,
  output lock_state_t state,
  output logic        f_inflight,
  output logic        l_inflight
);

  lock_state_t state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= UNLOCKED;
      f_inflight <= 1'b0;
      l_inflight <= 1'b0;
    end else begin
      state      <= state_next;
      f_inflight <= f_rd_issue;
      l_inflight <= l_rd_issue;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      UNLOCKED:  if (l_lock) state_next = f_inflight ? LOCK_PEND : LOCKED;
      LOCK_PEND: state_next = l_lock ? LOCKED : UNLOCKED;
      LOCKED:    if (!l_lock) state_next = UNLOCKED;
      default:   state_next = UNLOCKED;
    endcase
  end

endmodule

// File: rtl/prog_mem_arbiter.sv
// Program BRAM port-A arbiter between CPU fetch and program loader.
// Optional fetch stall counter enabled by PROG_MEM_ARB_STALL_CNT_EN.
import prog_mem_pkg::*;

module prog_mem_arbiter #(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FETCH_AW   = FETCH_AW_DEF,
  parameter int MAX_STREAK = MAX_STREAK_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  prog_mem_arbiter_if.slave   bus,
  output logic                locked,
  output logic [15:0]         stall_cnt
);

  localparam int STREAK_W = $clog2(MAX_STREAK + 1);

  lock_state_t         lock_state;
  logic                f_inflight;
  logic                l_inflight;
  logic                f_ack;
  logic                l_ack;
  logic [STREAK_W-1:0] streak;
  logic                streak_full;
  logic [DATA_W-1:0]   f_rdata_q;
  logic [DATA_W-1:0]   l_rdata_q;

  prog_mem_lock_fsm u_lock_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .l_lock     (bus.l_lock),
    .f_rd_issue (f_ack),
    .l_rd_issue (l_ack && !bus.l_we),
    .state      (lock_state),
    .f_inflight (f_inflight),
    .l_inflight (l_inflight)
  );

  assign streak_full = (streak == STREAK_W'(MAX_STREAK));

  always_comb begin
    f_ack = 1'b0;
    l_ack = 1'b0;
    unique case (lock_state)
      UNLOCKED: begin
        f_ack = bus.f_req && !(bus.l_req && streak_full);
        l_ack = bus.l_req && !f_ack;
      end
      LOCKED:  l_ack = bus.l_req;
      default: ;
    endcase
  end

  assign bus.f_ack   = f_ack;
  assign bus.l_ack   = l_ack;
  assign bus.m_addr  = l_ack ? bus.l_addr : {{(ADDR_W-FETCH_AW){1'b0}}, bus.f_addr};
  assign bus.m_we    = l_ack && bus.l_we;
  assign bus.m_wdata = bus.l_wdata;

  // Streak only counts fetch wins that actually made the loader wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    streak <= '0;
    else if (!bus.l_req || l_ack)  streak <= '0;
    else if (f_ack && !streak_full) streak <= streak + 1'b1;
  end

  // BRAM data appears in the rvalid cycle; the register keeps it afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      if (f_inflight) f_rdata_q <= bus.m_rdata;
      if (l_inflight) l_rdata_q <= bus.m_rdata;
    end
  end

  assign bus.f_rvalid = f_inflight;
  assign bus.l_rvalid = l_inflight;
  assign bus.f_rdata  = f_inflight ? bus.m_rdata : f_rdata_q;
  assign bus.l_rdata  = l_inflight ? bus.m_rdata : l_rdata_q;
  assign locked       = (lock_state == LOCKED);

`ifdef PROG_MEM_ARB_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (bus.f_req && !f_ack && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Randomized and directed bench for prog_mem_arbiter against a cycle-level reference model.
module tb_prog_mem_arbiter;

  localparam int MAX_STREAK = 4;
  localparam int M_FREE = 0, M_WAIT = 1, M_HELD = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        locked;
  logic [15:0] stall_cnt;

  prog_mem_arbiter_if bus ();

  prog_mem_arbiter u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .locked    (locked),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Read-first synchronous BRAM with one-cycle latency.
  logic [7:0] bram [2048] = '{default: 8'h00};
  always @(posedge clk) begin
    if (bus.m_we) bram[bus.m_addr] <= bus.m_wdata;
    bus.m_rdata <= bram[bus.m_addr];
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] shadow [2048] = '{default: 8'h00};
  int         md_mode, md_streak, md_stall;
  bit         md_f_pend, md_l_pend;
  logic [7:0] md_f_pd, md_l_pd, md_f_rd, md_l_rd;

  bit         last_f_ack, last_l_ack;
  logic       obs_f_ack, obs_l_ack, obs_m_we, obs_f_rvalid, obs_l_rvalid, obs_locked;
  logic [10:0] obs_m_addr;
  logic [7:0] obs_f_rdata, obs_l_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    md_mode = M_FREE; md_streak = 0; md_stall = 0;
    md_f_pend = 0; md_l_pend = 0;
    md_f_rd = 8'h00; md_l_rd = 8'h00;
    last_f_ack = 0; last_l_ack = 0;
  endtask

  task automatic drive(input logic fr, input logic [7:0] fa, input logic lr, input logic lw,
                       input logic [10:0] la, input logic [7:0] ld, input logic lk);
    bus.f_req = fr; bus.f_addr = fa;
    bus.l_req = lr; bus.l_we = lw; bus.l_addr = la; bus.l_wdata = ld; bus.l_lock = lk;
  endtask

  task automatic step();
    bit          e_f, e_l;
    logic [10:0] e_addr;
    @(negedge clk);
    e_f = 0; e_l = 0;
    if (md_mode == M_FREE) begin
      if (bus.f_req && bus.l_req) begin
        if (md_streak == MAX_STREAK) e_l = 1; else e_f = 1;
      end else if (bus.f_req) e_f = 1;
      else if (bus.l_req) e_l = 1;
    end else if (md_mode == M_HELD) begin
      e_l = bus.l_req;
    end
    e_addr = e_l ? bus.l_addr : {3'b000, bus.f_addr};

    check("f_ack",    32'(bus.f_ack),    32'(e_f));
    check("l_ack",    32'(bus.l_ack),    32'(e_l));
    check("m_addr",   32'(bus.m_addr),   32'(e_addr));
    check("m_we",     32'(bus.m_we),     32'(e_l && bus.l_we));
    if (e_l && bus.l_we) check("m_wdata", 32'(bus.m_wdata), 32'(bus.l_wdata));
    check("f_rvalid", 32'(bus.f_rvalid), 32'(md_f_pend));
    check("f_rdata",  32'(bus.f_rdata),  32'(md_f_pend ? md_f_pd : md_f_rd));
    check("l_rvalid", 32'(bus.l_rvalid), 32'(md_l_pend));
    check("l_rdata",  32'(bus.l_rdata),  32'(md_l_pend ? md_l_pd : md_l_rd));
    check("locked",   32'(locked),       32'(md_mode == M_HELD));
    check("stall_cnt", 32'(stall_cnt),   32'(md_stall));

    obs_f_ack = bus.f_ack; obs_l_ack = bus.l_ack; obs_m_we = bus.m_we; obs_m_addr = bus.m_addr;
    obs_f_rvalid = bus.f_rvalid; obs_l_rvalid = bus.l_rvalid; obs_locked = locked;
    obs_f_rdata = bus.f_rdata; obs_l_rdata = bus.l_rdata;

    @(posedge clk);
`ifdef PROG_MEM_ARB_STALL_CNT_EN
    if (bus.f_req && !e_f && md_stall < 65535) md_stall++;
`endif
    if (!bus.l_req || e_l) md_streak = 0;
    else if (e_f && md_streak < MAX_STREAK) md_streak++;
    case (md_mode)
      M_FREE:  if (bus.l_lock) md_mode = md_f_pend ? M_WAIT : M_HELD;
      M_WAIT:  md_mode = bus.l_lock ? M_HELD : M_FREE;
      default: if (!bus.l_lock) md_mode = M_FREE;
    endcase
    if (md_f_pend) md_f_rd = md_f_pd;
    if (md_l_pend) md_l_rd = md_l_pd;
    md_f_pend = e_f;
    md_l_pend = e_l && !bus.l_we;
    if (e_f) md_f_pd = shadow[e_addr];
    if (e_l && !bus.l_we) md_l_pd = shadow[e_addr];
    if (e_l && bus.l_we) shadow[e_addr] = bus.l_wdata;
    last_f_ack = e_f; last_l_ack = e_l;
    #1;
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #1;
    check("rst_locked",   32'(locked),       32'd0);
    check("rst_f_rvalid", 32'(bus.f_rvalid), 32'd0);
    check("rst_l_rvalid", 32'(bus.l_rvalid), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic rand_drive();
    if (!bus.f_req || last_f_ack) begin
      bus.f_req  = ($urandom_range(0, 99) < 60);
      bus.f_addr = 8'($urandom_range(0, 63));
    end
    if (!bus.l_req || last_l_ack) begin
      bus.l_req   = ($urandom_range(0, 99) < 45);
      bus.l_we    = 1'($urandom_range(0, 1));
      bus.l_addr  = 11'($urandom_range(0, 63));
      bus.l_wdata = 8'($urandom);
    end
    if ($urandom_range(0, 29) == 0) bus.l_lock = !bus.l_lock;
  endtask

  initial begin
    logic [9:0] pat;
    int         nacks;
    rst_n = 1'b0;
    drive(0, 8'h00, 0, 0, 11'h000, 8'h00, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) step();

    // Fetch only from 0x03 preloaded with 0x42
    drive(0, 8'h00, 1, 1, 11'h003, 8'h42, 0); step();
    drive(1, 8'h03, 0, 0, 11'h000, 8'h00, 0); step();
    check("fetch_ack",  32'(obs_f_ack),  32'd1);
    check("fetch_addr", 32'(obs_m_addr), 32'h003);
    drive(0, 8'h00, 0, 0, 11'h000, 8'h00, 0); step();
    check("fetch_rvalid", 32'(obs_f_rvalid), 32'd1);
    check("fetch_rdata",  32'(obs_f_rdata),  32'h42);
    check("fetch_no_lrv", 32'(obs_l_rvalid), 32'd0);

    // Both requesting continuously
    for (int i = 0; i < 10; i++) begin
      drive(1, 8'(i), 1, 0, 11'(32 + i), 8'h00, 0); step();
      pat[i] = obs_l_ack;
    end
    check("streak_pattern", 32'(pat), 32'(10'b1000010000));
    drive(0, 8'h00, 0, 0, 11'h000, 8'h00, 0); step();

    // Loader write then read back
    drive(0, 8'h00, 1, 1, 11'h010, 8'hA5, 0); step();
    check("lwr_we", 32'(obs_m_we), 32'd1);
    drive(0, 8'h00, 1, 0, 11'h010, 8'h00, 0); step();
    check("lrd_ack", 32'(obs_l_ack), 32'd1);
    check("lrd_we",  32'(obs_m_we),  32'd0);
    drive(0, 8'h00, 0, 0, 11'h000, 8'h00, 0); step();
    check("lrd_rvalid", 32'(obs_l_rvalid), 32'd1);
    check("lrd_rdata",  32'(obs_l_rdata),  32'hA5);

    // Lock raised the cycle after a fetch ack
    drive(1, 8'h05, 0, 0, 11'h000, 8'h00, 0); step();
    drive(0, 8'h00, 0, 0, 11'h000, 8'h00, 1); step();
    check("lock_f_rvalid", 32'(obs_f_rvalid), 32'd1);
    drive(1, 8'h07, 0, 0, 11'h000, 8'h00, 1); step();
    check("lock_pend_locked", 32'(obs_locked), 32'd0);
    nacks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (obs_f_ack) nacks++;
    end
    check("locked_fetch_acks", 32'(nacks), 32'd0);
    check("locked_flag", 32'(obs_locked), 32'd1);
    drive(1, 8'h07, 1, 1, 11'h011, 8'h5A, 1); step();
    check("locked_l_ack", 32'(obs_l_ack), 32'd1);
    drive(0, 8'h00, 0, 0, 11'h000, 8'h00, 1); step();

    // Reset while locked, then reset with a fetch read in flight
    drive(0, 8'h00, 0, 0, 11'h000, 8'h00, 0);
    pulse_reset();
    step();
    drive(1, 8'h03, 0, 0, 11'h000, 8'h00, 0); step();
    drive(0, 8'h00, 0, 0, 11'h000, 8'h00, 0);
    pulse_reset();
    step();
    check("post_rst_f_rvalid", 32'(obs_f_rvalid), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rand_drive();
      step();
    end
    drive(0, 8'h00, 0, 0, 11'h000, 8'h00, 0);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
